// File: rtl/mem_access_ctrl_if.sv
// Request, response and data-RAM signal bundle for mem_access_ctrl.
// slave: the controller's view. master: the surrounding pipeline/RAM view.
interface mem_access_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_load;
  logic        in_store;
  logic [9:0]  in_funct;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        ram_r_en;
  logic        ram_w_en;
  logic [9:0]  ram_funct;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  in_valid, in_load, in_store, in_funct, in_addr, in_wdata, in_rd,
           out_ready, ram_rdata,
    output in_ready, out_valid, out_rdata, out_rd,
           ram_r_en, ram_w_en, ram_funct, ram_addr, ram_wdata
  );

  modport master (
    output in_valid, in_load, in_store, in_funct, in_addr, in_wdata, in_rd,
           out_ready, ram_rdata,
    input  in_ready, out_valid, out_rdata, out_rd,
           ram_r_en, ram_w_en, ram_funct, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues aligned accesses directly, splits
// misaligned loads into two word reads and misaligned stores into byte writes.
`ifndef MEM_ACCESS_FUNC_DEFS
`define MEM_ACCESS_FUNC_DEFS
`define FUNC_LB  10'h000
`define FUNC_LH  10'h001
`define FUNC_LW  10'h002
`define FUNC_LBU 10'h004
`define FUNC_LHU 10'h005
`define FUNC_SB  10'h008
`define FUNC_SH  10'h009
`define FUNC_SW  10'h00A
`endif

module mem_access_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, LD_LO, LD_HI, ACCESS, ST_BYTE, RESP} state_t;

  state_t      state, state_nxt;
  logic [9:0]  req_funct;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        req_load;
  logic        req_store;
  logic [1:0]  byte_cnt;
  logic [31:0] lo_word;
  logic [31:0] out_rdata_q;

  logic        in_ld, in_st, in_mis, st_last;
  logic [31:0] lo_base;
  logic [63:0] pair;
  logic [31:0] mis_word;
  logic [31:0] mis_data;

  function automatic logic is_word(input logic [9:0] f);
    return (f == `FUNC_LW) || (f == `FUNC_SW);
  endfunction

  function automatic logic is_half(input logic [9:0] f);
    return (f == `FUNC_LH) || (f == `FUNC_LHU) || (f == `FUNC_SH);
  endfunction

  // Load wins when both flags are set.
  assign in_ld   = bus.in_load;
  assign in_st   = bus.in_store && !bus.in_load;
  assign in_mis  = (is_word(bus.in_funct) && (bus.in_addr[1:0] != 2'd0)) ||
                   (is_half(bus.in_funct) && (bus.in_addr[1:0] == 2'd3));
  assign st_last = is_half(req_funct) ? (byte_cnt == 2'd1) : (byte_cnt == 2'd3);
  assign lo_base = {req_addr[31:2], 2'b00};

  assign pair     = {bus.ram_rdata, lo_word};
  assign mis_word = pair[{req_addr[1:0], 3'b000} +: 32];

  // Extend the recombined misaligned load according to its access code.
  always_comb begin
    mis_data = mis_word;
    if (req_funct == `FUNC_LH)
      mis_data = {{16{mis_word[15]}}, mis_word[15:0]};
    else if (req_funct == `FUNC_LHU)
      mis_data = {16'h0000, mis_word[15:0]};
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == RESP);
  assign bus.out_rdata = out_rdata_q;
  assign bus.out_rd    = req_rd;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection and RAM drive, from state and registered request only.
  always_comb begin
    state_nxt     = state;
    bus.ram_r_en  = 1'b0;
    bus.ram_w_en  = 1'b0;
    bus.ram_funct = req_funct;
    bus.ram_addr  = req_addr;
    bus.ram_wdata = req_wdata;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (!in_ld && !in_st) state_nxt = RESP;
          else if (in_mis)      state_nxt = in_ld ? LD_LO : ST_BYTE;
          else                  state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        bus.ram_r_en = req_load;
        bus.ram_w_en = req_store;
        state_nxt    = RESP;
      end
      LD_LO: begin
        bus.ram_r_en  = 1'b1;
        bus.ram_funct = `FUNC_LW;
        bus.ram_addr  = lo_base;
        state_nxt     = LD_HI;
      end
      LD_HI: begin
        bus.ram_r_en  = 1'b1;
        bus.ram_funct = `FUNC_LW;
        bus.ram_addr  = lo_base + 32'd4;
        state_nxt     = RESP;
      end
      ST_BYTE: begin
        bus.ram_w_en  = 1'b1;
        bus.ram_funct = `FUNC_SB;
        bus.ram_addr  = req_addr + {30'd0, byte_cnt};
        bus.ram_wdata = {24'd0, req_wdata[{byte_cnt, 3'b000} +: 8]};
        if (st_last) state_nxt = RESP;
      end
      RESP: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, byte counter and load result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_funct   <= '0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_rd      <= '0;
      req_load    <= 1'b0;
      req_store   <= 1'b0;
      byte_cnt    <= '0;
      lo_word     <= '0;
      out_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            req_funct   <= bus.in_funct;
            req_addr    <= bus.in_addr;
            req_wdata   <= bus.in_wdata;
            req_rd      <= bus.in_rd;
            req_load    <= in_ld;
            req_store   <= in_st;
            byte_cnt    <= '0;
            out_rdata_q <= '0;
          end
        end
        ACCESS:  if (req_load) out_rdata_q <= bus.ram_rdata;
        LD_LO:   lo_word <= bus.ram_rdata;
        LD_HI:   out_rdata_q <= mis_data;
        ST_BYTE: byte_cnt <= st_last ? 2'd0 : byte_cnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a small behavioural data RAM.
`ifndef MEM_ACCESS_FUNC_DEFS
`define MEM_ACCESS_FUNC_DEFS
`define FUNC_LB  10'h000
`define FUNC_LH  10'h001
`define FUNC_LW  10'h002
`define FUNC_LBU 10'h004
`define FUNC_LHU 10'h005
`define FUNC_SB  10'h008
`define FUNC_SH  10'h009
`define FUNC_SW  10'h00A
`endif

module tb_mem_access_ctrl;
  logic clk;
  logic rst_n;
  mem_access_ctrl_if bus();

  mem_access_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  int lat;

  logic [31:0] mem [0:63];
  logic [31:0] wr_addr_q[$];
  logic [9:0]  wr_funct_q[$];
  logic [7:0]  wr_data_q[$];
  logic [31:0] rd_addr_q[$];
  logic [9:0]  rd_funct_q[$];
  int          both_cnt = 0;
  logic [31:0] rd_w, wtmp;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM read port: extracts and extends the addressed item.
  always_comb begin
    rd_w = mem[bus.ram_addr[7:2]];
    rd_b = rd_w[{bus.ram_addr[1:0], 3'b000} +: 8];
    rd_h = bus.ram_addr[1] ? rd_w[31:16] : rd_w[15:0];
    bus.ram_rdata = 32'h0;
    if (bus.ram_r_en) begin
      case (bus.ram_funct)
        `FUNC_LB:  bus.ram_rdata = {{24{rd_b[7]}}, rd_b};
        `FUNC_LBU: bus.ram_rdata = {24'h0, rd_b};
        `FUNC_LH:  bus.ram_rdata = {{16{rd_h[15]}}, rd_h};
        `FUNC_LHU: bus.ram_rdata = {16'h0, rd_h};
        default:   bus.ram_rdata = rd_w;
      endcase
    end
  end

  // RAM write port plus access logging.
  always @(posedge clk) begin
    if (bus.ram_w_en) begin
      wr_addr_q.push_back(bus.ram_addr);
      wr_funct_q.push_back(bus.ram_funct);
      wr_data_q.push_back(bus.ram_wdata[7:0]);
      wtmp = mem[bus.ram_addr[7:2]];
      case (bus.ram_funct)
        `FUNC_SB: wtmp[{bus.ram_addr[1:0], 3'b000} +: 8] = bus.ram_wdata[7:0];
        `FUNC_SH: wtmp[{bus.ram_addr[1], 4'b0000} +: 16] = bus.ram_wdata[15:0];
        default:  wtmp = bus.ram_wdata;
      endcase
      mem[bus.ram_addr[7:2]] <= wtmp;
    end
    if (bus.ram_r_en) begin
      rd_addr_q.push_back(bus.ram_addr);
      rd_funct_q.push_back(bus.ram_funct);
    end
    if (bus.ram_r_en && bus.ram_w_en) both_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic clear_logs();
    wr_addr_q.delete(); wr_funct_q.delete(); wr_data_q.delete();
    rd_addr_q.delete(); rd_funct_q.delete();
  endtask

  // Present one request, wait for out_valid; lat = cycles after accept, 0 on timeout.
  task automatic issue(input logic ld, input logic st, input logic [9:0] f,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, output int l);
    int guard;
    clear_logs();
    @(negedge clk);
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    bus.in_valid = 1'b1; bus.in_load = ld; bus.in_store = st;
    bus.in_funct = f; bus.in_addr = a; bus.in_wdata = wd; bus.in_rd = rd;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_load = 1'b0; bus.in_store = 1'b0;
    l = 1;
    while (bus.out_valid !== 1'b1 && l < 20) begin @(negedge clk); l++; end
    if (bus.out_valid !== 1'b1) l = 0;
  endtask

  task automatic release_resp();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_rdata !== 32'h0) begin n_err++; $display("FAIL rst_out_rdata: got %h want 0", bus.out_rdata); end
    n_cmp++; if (bus.out_rd !== 5'd0) begin n_err++; $display("FAIL rst_out_rd: got %0d want 0", bus.out_rd); end
    n_cmp++; if ({bus.ram_r_en, bus.ram_w_en} !== 2'b00) begin n_err++; $display("FAIL rst_ram_en: got %b want 00", {bus.ram_r_en, bus.ram_w_en}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_aligned_load();
    mem[4] = 32'hDEADBEEF;
    issue(1'b1, 1'b0, `FUNC_LW, 32'h8000_0010, 32'h0, 5'd5, lat);
    n_cmp++; if (lat != 2) begin n_err++; $display("FAIL lw_latency: got %0d want 2", lat); end
    n_cmp++; if (bus.out_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_rdata: got %h want deadbeef", bus.out_rdata); end
    n_cmp++; if (bus.out_rd !== 5'd5) begin n_err++; $display("FAIL lw_rd: got %0d want 5", bus.out_rd); end
    n_cmp++; if (!(rd_addr_q.size() == 1 && rd_addr_q[0] == 32'h8000_0010 && rd_funct_q[0] == `FUNC_LW)) begin n_err++; $display("FAIL lw_reads: got %0d reads want 1 LW at 80000010", rd_addr_q.size()); end
    n_cmp++; if (wr_addr_q.size() != 0) begin n_err++; $display("FAIL lw_writes: got %0d want 0", wr_addr_q.size()); end
    release_resp();
    n_cmp++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin n_err++; $display("FAIL lw_release: got valid/ready %b want 01", {bus.out_valid, bus.in_ready}); end
    mem[20] = 32'h80FF_0000;
    issue(1'b1, 1'b0, `FUNC_LB, 32'h8000_0053, 32'h0, 5'd6, lat);
    n_cmp++; if (bus.out_rdata !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_rdata: got %h want ffffff80", bus.out_rdata); end
    release_resp();
  endtask

  task automatic test_misaligned_load();
    mem[0] = 32'h11223344; mem[1] = 32'h556677AA;
    issue(1'b1, 1'b0, `FUNC_LH, 32'h8000_0003, 32'h0, 5'd9, lat);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL lh_latency: got %0d want 3", lat); end
    n_cmp++; if (bus.out_rdata !== 32'hFFFFAA11) begin n_err++; $display("FAIL lh_rdata: got %h want ffffaa11", bus.out_rdata); end
    n_cmp++; if (!(rd_addr_q.size() == 2 && rd_addr_q[0] == 32'h8000_0000 && rd_addr_q[1] == 32'h8000_0004 &&
                   rd_funct_q[0] == `FUNC_LW && rd_funct_q[1] == `FUNC_LW)) begin
      n_err++; $display("FAIL lh_reads: got %0d reads want LW 80000000 then 80000004", rd_addr_q.size()); end
    release_resp();
    issue(1'b1, 1'b0, `FUNC_LHU, 32'h8000_0003, 32'h0, 5'd9, lat);
    n_cmp++; if (bus.out_rdata !== 32'h0000AA11) begin n_err++; $display("FAIL lhu_rdata: got %h want 0000aa11", bus.out_rdata); end
    release_resp();
    issue(1'b1, 1'b0, `FUNC_LW, 32'h8000_0001, 32'h0, 5'd9, lat);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL lw_mis_latency: got %0d want 3", lat); end
    n_cmp++; if (bus.out_rdata !== 32'hAA112233) begin n_err++; $display("FAIL lw_mis_rdata: got %h want aa112233", bus.out_rdata); end
    release_resp();
    mem[63] = 32'hCCDDEEFF;
    issue(1'b1, 1'b0, `FUNC_LW, 32'hFFFF_FFFE, 32'h0, 5'd1, lat);
    n_cmp++; if (!(rd_addr_q.size() == 2 && rd_addr_q[0] == 32'hFFFF_FFFC && rd_addr_q[1] == 32'h0000_0000)) begin
      n_err++; $display("FAIL lw_wrap_reads: got %0d reads want fffffffc then 00000000", rd_addr_q.size()); end
    n_cmp++; if (bus.out_rdata !== 32'h3344CCDD) begin n_err++; $display("FAIL lw_wrap_rdata: got %h want 3344ccdd", bus.out_rdata); end
    release_resp();
  endtask

  task automatic test_aligned_store();
    issue(1'b0, 1'b1, `FUNC_SW, 32'h8000_0020, 32'hCAFEF00D, 5'd2, lat);
    n_cmp++; if (lat != 2) begin n_err++; $display("FAIL sw_latency: got %0d want 2", lat); end
    n_cmp++; if (bus.out_rdata !== 32'h0) begin n_err++; $display("FAIL sw_rdata: got %h want 0", bus.out_rdata); end
    n_cmp++; if (!(wr_addr_q.size() == 1 && wr_funct_q[0] == `FUNC_SW)) begin n_err++; $display("FAIL sw_writes: got %0d writes want 1 SW", wr_addr_q.size()); end
    n_cmp++; if (mem[8] !== 32'hCAFEF00D) begin n_err++; $display("FAIL sw_mem: got %h want cafef00d", mem[8]); end
    release_resp();
    issue(1'b0, 1'b1, `FUNC_SH, 32'h8000_0026, 32'h0000_1234, 5'd2, lat);
    n_cmp++; if (mem[9] !== 32'h12340000) begin n_err++; $display("FAIL sh_mem: got %h want 12340000", mem[9]); end
    release_resp();
  endtask

  task automatic test_misaligned_store();
    logic [31:0] exp_a [4];
    logic [7:0]  exp_d [4];
    exp_a = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0003, 32'h8000_0004};
    exp_d = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    mem[0] = 32'h11223344; mem[1] = 32'h556677AA;
    issue(1'b0, 1'b1, `FUNC_SW, 32'h8000_0001, 32'hA1B2C3D4, 5'd4, lat);
    n_cmp++; if (lat != 5) begin n_err++; $display("FAIL sw_mis_latency: got %0d want 5", lat); end
    n_cmp++; if (wr_addr_q.size() != 4) begin n_err++; $display("FAIL sw_mis_count: got %0d want 4", wr_addr_q.size()); end
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < wr_addr_q.size()) begin
        n_cmp++;
        if (wr_addr_q[k] !== exp_a[k] || wr_data_q[k] !== exp_d[k] || wr_funct_q[k] !== `FUNC_SB) begin
          n_err++; $display("FAIL sw_mis_byte%0d: got %h/%h/%h want %h/%h/SB", k, wr_addr_q[k], wr_data_q[k], wr_funct_q[k], exp_a[k], exp_d[k]);
        end
      end
    end
    n_cmp++; if (mem[0] !== 32'hB2C3D444 || mem[1] !== 32'h556677A1) begin n_err++; $display("FAIL sw_mis_mem: got %h %h want b2c3d444 556677a1", mem[0], mem[1]); end
    release_resp();
    issue(1'b0, 1'b1, `FUNC_SH, 32'h8000_0023, 32'h0000_BEEF, 5'd4, lat);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL sh_mis_latency: got %0d want 3", lat); end
    n_cmp++; if (mem[8] !== 32'hEFFEF00D || mem[9] !== 32'h123400BE) begin n_err++; $display("FAIL sh_mis_mem: got %h %h want effef00d 123400be", mem[8], mem[9]); end
    release_resp();
  endtask

  task automatic test_resp_hold();
    issue(1'b1, 1'b0, `FUNC_LW, 32'h8000_0010, 32'h0, 5'd3, lat);
    bus.in_valid = 1'b1; bus.in_load = 1'b1; bus.in_funct = `FUNC_LW; bus.in_addr = 32'h8000_0020; bus.in_rd = 5'd17;
    for (int unsigned c = 0; c < 3; c++) begin
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.ram_r_en, bus.ram_w_en} !== 4'b1000 || bus.out_rdata !== 32'hDEADBEEF || bus.out_rd !== 5'd3) begin
        n_err++; $display("FAIL hold_c%0d: got v/r/re/we %b rdata %h rd %0d want 1000 deadbeef 3", c,
                          {bus.out_valid, bus.in_ready, bus.ram_r_en, bus.ram_w_en}, bus.out_rdata, bus.out_rd);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.in_load = 1'b0;
    n_cmp++; if (rd_addr_q.size() != 1) begin n_err++; $display("FAIL hold_reads: got %0d want 1", rd_addr_q.size()); end
    release_resp();
  endtask

  task automatic test_reset_in_store();
    mem[16] = 32'h0;
    clear_logs();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_store = 1'b1; bus.in_funct = `FUNC_SW;
    bus.in_addr = 32'h8000_0041; bus.in_wdata = 32'h11223344; bus.in_rd = 5'd7;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_store = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ram_w_en !== 1'b1 || bus.ram_addr !== 32'h8000_0042) begin n_err++; $display("FAIL rst_st_second: got we %b addr %h want 1 80000042", bus.ram_w_en, bus.ram_addr); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ram_r_en, bus.ram_w_en, bus.out_valid, bus.in_ready} !== 4'b0001 || bus.out_rdata !== 32'h0 || bus.out_rd !== 5'd0) begin
      n_err++; $display("FAIL rst_st_async: got re/we/v/rdy %b rdata %h rd %0d want 0001 0 0",
                        {bus.ram_r_en, bus.ram_w_en, bus.out_valid, bus.in_ready}, bus.out_rdata, bus.out_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (!(wr_addr_q.size() == 1 && wr_data_q[0] == 8'h44)) begin n_err++; $display("FAIL rst_st_writes: got %0d writes want 1 of 44", wr_addr_q.size()); end
    n_cmp++; if (mem[16] !== 32'h00004400) begin n_err++; $display("FAIL rst_st_mem: got %h want 00004400", mem[16]); end
    n_cmp++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin n_err++; $display("FAIL rst_st_idle: got rdy/v %b want 10", {bus.in_ready, bus.out_valid}); end
  endtask

  task automatic test_both_flags();
    mem[20] = 32'h00FF_0000;
    issue(1'b1, 1'b1, `FUNC_LBU, 32'h8000_0052, 32'h12345678, 5'd4, lat);
    n_cmp++; if (lat != 2) begin n_err++; $display("FAIL both_latency: got %0d want 2", lat); end
    n_cmp++; if (bus.out_rdata !== 32'h000000FF) begin n_err++; $display("FAIL both_rdata: got %h want 000000ff", bus.out_rdata); end
    n_cmp++; if (wr_addr_q.size() != 0 || rd_addr_q.size() != 1) begin n_err++; $display("FAIL both_access: got %0d writes %0d reads want 0 1", wr_addr_q.size(), rd_addr_q.size()); end
    n_cmp++; if (mem[20] !== 32'h00FF_0000) begin n_err++; $display("FAIL both_mem: got %h want 00ff0000", mem[20]); end
    release_resp();
  endtask

  task automatic test_nonmem();
    issue(1'b0, 1'b0, `FUNC_LW, 32'h8000_0013, 32'hFFFF_FFFF, 5'd12, lat);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL nm_latency: got %0d want 1", lat); end
    n_cmp++; if (bus.out_rdata !== 32'h0 || bus.out_rd !== 5'd12) begin n_err++; $display("FAIL nm_result: got %h rd %0d want 0 12", bus.out_rdata, bus.out_rd); end
    n_cmp++; if (wr_addr_q.size() != 0 || rd_addr_q.size() != 0) begin n_err++; $display("FAIL nm_access: got %0d writes %0d reads want 0 0", wr_addr_q.size(), rd_addr_q.size()); end
    release_resp();
    n_cmp++; if (both_cnt != 0) begin n_err++; $display("FAIL never_both_en: got %0d cycles want 0", both_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_load = 1'b0; bus.in_store = 1'b0;
    bus.in_funct = '0; bus.in_addr = '0; bus.in_wdata = '0; bus.in_rd = '0;
    bus.out_ready = 1'b0;
    for (int unsigned i = 0; i < 64; i++) mem[i] = 32'h0;
    test_reset();
    test_aligned_load();
    test_misaligned_load();
    test_aligned_store();
    test_misaligned_store();
    test_resp_hold();
    test_reset_in_store();
    test_both_flags();
    test_nonmem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on posedge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  request from EX/MEM register valid.
REQ-004 in_ready  output  1  block can accept a request this cycle.
REQ-005 in_load  input  1  request is a load.
REQ-006 in_store  input  1  request is a store.
REQ-007 in_funct  input  10  access code; uses the shared `FUNC_LB/LH/LW/LBU/LHU/SB/SH/SW` defines.
REQ-008 in_addr  input  32  byte address.
REQ-009 in_wdata  input  32  store data, LSB-aligned.
REQ-010 in_rd  input  5  destination register tag, passed through.
REQ-011 out_valid  output  1  result for WB valid.
REQ-012 out_ready  input  1  WB accepts result.
REQ-013 out_rdata  output  32  extended load data; 0 for stores and non-memory requests.
REQ-014 out_rd  output  5  registered in_rd.
REQ-015 ram_r_en, ram_w_en  output  1 each  data RAM enables.
REQ-016 ram_funct  output  10  access code to RAM.
REQ-017 ram_addr  output  32  RAM address.
REQ-018 ram_wdata  output  32  RAM write data.
REQ-019 ram_rdata  input  32  RAM read data; combinational in ram_addr/ram_funct/ram_r_en.

Function
REQ-020 States: IDLE, LD_LO, LD_HI, ACCESS, ST_BYTE, RESP; ram_* outputs are combinational from state and registered request only.
REQ-021 in_ready = (state==IDLE); accept on in_valid && in_ready; register funct, addr, wdata, rd, load/store flags.
REQ-022 Classification: misaligned = LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[1:0]==3; all else aligned.
REQ-023 in_load and in_store both set -> treated as load; neither set -> IDLE->RESP, no RAM enable, out_rdata=0.
REQ-024 Aligned access: IDLE->ACCESS->RESP; ACCESS drives original funct and addr, r_en (load) or w_en (store) for exactly one cycle; load result = ram_rdata captured at end of ACCESS.
REQ-025 Misaligned load: IDLE->LD_LO->LD_HI->RESP; LD_LO reads FUNC_LW at {addr[31:2],2'b00}; LD_HI reads FUNC_LW at that address +4 (32-bit wrap, 0xFFFFFFFC+4=0x00000000).
REQ-026 Misaligned load data = ({hi,lo} >> 8*addr[1:0]) truncated to 16/32 bits; sign-extended for LH, zero-extended for LHU.
REQ-027 Misaligned store: IDLE->ST_BYTE x N->RESP, N=2 (SH) or 4 (SW); byte k (k=0..N-1) written with FUNC_SB at addr+k, ram_wdata[7:0]=wdata[8k+7:8k], one byte per cycle, 2-bit byte counter.
REQ-028 ram_w_en asserted only in ACCESS(store) and ST_BYTE; ram_r_en only in ACCESS(load), LD_LO, LD_HI; never both.
REQ-029 RESP: out_valid=1, out_rdata/out_rd held stable until out_ready; out_valid && out_ready -> IDLE next cycle; no new request accepted in RESP.
REQ-030 Latency accept->out_valid: aligned 2 cycles, misaligned load 3, SH 3, SW 5, non-memory 1.

Reset
REQ-031 rst_n low asynchronously forces state=IDLE, out_valid=0, out_rdata=0, out_rd=0, byte counter=0, all request registers 0; ram_r_en=ram_w_en=0 immediately.
REQ-032 Reset during ST_BYTE aborts the store; bytes already written stay written; no retry after reset.

Verification
REQ-033 LW addr 0x80000010, mem word 0xDEADBEEF -> out_valid 2 cycles after accept, out_rdata=0xDEADBEEF, single r_en cycle.
REQ-034 LH addr 0x80000003, words 0x80000000=0x11223344, 0x80000004=0x556677AA -> reads 0x80000000 then 0x80000004, out_rdata=0xFFFFAA11.
REQ-035 SW addr 0x80000001, wdata 0xA1B2C3D4 -> four SB writes 0x80000001..04 data D4,C3,B2,A1, out_valid 5 cycles after accept.
REQ-036 out_ready held low 3 cycles in RESP -> out_valid and out_rdata stable, in_ready=0, no RAM enable.
REQ-037 rst_n pulsed low in second ST_BYTE cycle of SW -> outputs zero immediately, state IDLE, in_ready=1 after release, only first byte written.
REQ-038 in_load=in_store=1, LBU addr 0x80000002, word 0x00FF0000 -> no write, out_rdata=0x000000FF.
